// File: rtl/stack_cpu_ctrl.sv
// Multi-cycle control FSM for the stack processor: fetch/decode, stack sequencing,
// occupancy tracking and overflow/underflow trap.
module stack_cpu_ctrl #(
    parameter  int DEPTH = 32,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [2:0]    opcode_i,
    input  logic          zero_i,
    output logic          ir_write_o,
    output logic          pc_write_o,
    output logic          pc_src_o,
    output logic          i_or_d_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic          push_o,
    output logic          pop_o,
    output logic          tos_o,
    output logic          stk_src_o,
    output logic          a_write_o,
    output logic          b_write_o,
    output logic [1:0]    alu_op_o,
    output logic [DW-1:0] depth_o,
    output logic          busy_o,
    output logic          err_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_POP1, S_POP2, S_LATCH_B, S_LATCH_A,
        S_EXEC, S_PUSH_M, S_STORE, S_JUMP, S_TOS1, S_JZ_EVAL, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;

    // State and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            depth_q <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
        end
    end

    // Next-state logic; DECODE refuses any instruction that would over/underflow
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
                else         state_d = S_IDLE;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    3'b000, 3'b001, 3'b010:
                        state_d = (depth_q >= DW'(2)) ? S_POP1 : S_ERR;
                    3'b011, 3'b101:
                        state_d = (depth_q >= DW'(1)) ? S_POP1 : S_ERR;
                    3'b100:
                        state_d = (depth_q < DW'(DEPTH)) ? S_PUSH_M : S_ERR;
                    3'b110:
                        state_d = S_JUMP;
                    3'b111:
                        state_d = (depth_q >= DW'(1)) ? S_TOS1 : S_ERR;
                    default:
                        state_d = S_ERR;
                endcase
            end
            S_POP1: begin
                case (opcode_i)
                    3'b000, 3'b001, 3'b010: state_d = S_POP2;
                    3'b011:                 state_d = S_LATCH_A;
                    3'b101:                 state_d = S_STORE;
                    default:                state_d = S_ERR;
                endcase
            end
            S_POP2:    state_d = S_LATCH_B;
            S_LATCH_B: state_d = S_EXEC;
            S_LATCH_A: state_d = S_EXEC;
            S_EXEC:    state_d = S_FETCH;
            S_PUSH_M:  state_d = S_FETCH;
            S_STORE:   state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_TOS1:    state_d = S_JZ_EVAL;
            S_JZ_EVAL: state_d = S_FETCH;
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_ERR;
        endcase
    end

    // Moore output decode; pc_write in JZ_EVAL follows the zero flag directly
    always_comb begin
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 1'b0;
        i_or_d_o    = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        push_o      = 1'b0;
        pop_o       = 1'b0;
        tos_o       = 1'b0;
        stk_src_o   = 1'b0;
        a_write_o   = 1'b0;
        b_write_o   = 1'b0;
        busy_o      = 1'b1;
        err_o       = 1'b0;
        case (state_q)
            S_IDLE: busy_o = 1'b0;
            S_FETCH: begin
                mem_read_o = 1'b1;
                ir_write_o = 1'b1;
                pc_write_o = 1'b1;
            end
            S_DECODE: busy_o = 1'b1;
            S_POP1:   pop_o  = 1'b1;
            S_POP2: begin
                pop_o     = 1'b1;
                a_write_o = 1'b1;
            end
            S_LATCH_B: b_write_o = 1'b1;
            S_LATCH_A: a_write_o = 1'b1;
            S_EXEC:    push_o    = 1'b1;
            S_PUSH_M: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                push_o     = 1'b1;
                stk_src_o  = 1'b1;
            end
            S_STORE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 1'b1;
            end
            S_TOS1: tos_o = 1'b1;
            S_JZ_EVAL: begin
                pc_src_o   = 1'b1;
                pc_write_o = zero_i;
            end
            S_ERR: begin
                busy_o = 1'b0;
                err_o  = 1'b1;
            end
            default: busy_o = 1'b0;
        endcase
    end

    // Occupancy follows the stack commands; push and pop are never issued together
    always_comb begin
        if (push_o) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_o) begin
            depth_d = depth_q - DW'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    assign alu_op_o = opcode_i[1:0];
    assign depth_o  = depth_q;

endmodule

// File: tb/tb_stack_cpu_ctrl.sv
// Directed table-driven bench for stack_cpu_ctrl: per-cycle control words per instruction,
// plus trap, overflow and mid-instruction reset sequences.
module tb_stack_cpu_ctrl;

    localparam logic [11:0] IRW  = 12'h800, PCW = 12'h400, PCS = 12'h200, IOD = 12'h100;
    localparam logic [11:0] MRD  = 12'h080, MWR = 12'h040, PSH = 12'h020, POPB = 12'h010;
    localparam logic [11:0] TOSB = 12'h008, SSR = 12'h004, AW  = 12'h002, BW   = 12'h001;
    localparam logic [11:0] W0      = 12'h000;
    localparam logic [11:0] W_FETCH = IRW | PCW | MRD;
    localparam logic [11:0] W_PUSHM = MRD | IOD | PSH | SSR;
    localparam logic [11:0] W_STORE = MWR | IOD;
    localparam logic [11:0] W_JUMP  = PCW | PCS;

    typedef struct packed {
        logic [2:0]       op;
        logic             z;
        logic [2:0]       len;
        logic [5:0][11:0] w;      // w[0] is the FETCH cycle
        logic [5:0]       d;      // expected depth after the instruction
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, zero_i = 1'b0;
    logic [2:0] opcode_i = 3'b000;
    logic ir_write_o, pc_write_o, pc_src_o, i_or_d_o, mem_read_o, mem_write_o;
    logic push_o, pop_o, tos_o, stk_src_o, a_write_o, b_write_o, busy_o, err_o;
    logic [1:0] alu_op_o;
    logic [5:0] depth_o;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t tbl [12];

    stack_cpu_ctrl #(.DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .push_o(push_o), .pop_o(pop_o), .tos_o(tos_o), .stk_src_o(stk_src_o),
        .a_write_o(a_write_o), .b_write_o(b_write_o), .alu_op_o(alu_op_o),
        .depth_o(depth_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ctrl_word();
        return {ir_write_o, pc_write_o, pc_src_o, i_or_d_o, mem_read_o, mem_write_o,
                push_o, pop_o, tos_o, stk_src_o, a_write_o, b_write_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Runs one instruction starting at its FETCH cycle and checks every cycle plus final depth.
    task automatic apply(input string tag, input vec_t v);
        for (int c = 0; c < int'(v.len); c++) begin
            @(negedge clk);
            if (c == 0) begin
                opcode_i = v.op;
                zero_i   = v.z;
            end
            #1;
            chk($sformatf("%s_c%0d", tag, c + 1),
                {16'h0, ctrl_word(), busy_o, err_o, alu_op_o},
                {16'h0, v.w[c], 1'b1, 1'b0, v.op[1:0]});
        end
        @(posedge clk);
        #1;
        chk($sformatf("%s_depth", tag), {26'h0, depth_o}, {26'h0, v.d});
    endtask

    // Instruction that must trap in DECODE; ERR is then held for 20 cycles.
    task automatic err_seq(input string tag, input logic [2:0] op, input logic [5:0] d);
        @(negedge clk);
        opcode_i = op;
        #1;
        chk({tag, "_fetch"}, {19'h0, ctrl_word(), busy_o}, {19'h0, W_FETCH, 1'b1});
        @(negedge clk);
        #1;
        chk({tag, "_decode"}, {19'h0, ctrl_word(), busy_o}, {19'h0, W0, 1'b1});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("%s_err%0d", tag, c),
                {12'h0, ctrl_word(), busy_o, err_o, depth_o},
                {12'h0, W0, 1'b0, 1'b1, d});
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        start_i = 1'b0;
        #1;
        chk({tag, "_rst"}, {12'h0, ctrl_word(), busy_o, err_o, depth_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic go();
        @(negedge clk);
        start_i = 1'b1;
    endtask

    initial begin
        vec_t pv;
        tbl[0]  = '{3'b100, 1'b0, 3'd3, {W0, W0, W0, W_PUSHM, W0, W_FETCH}, 6'd1};
        tbl[1]  = '{3'b100, 1'b0, 3'd3, {W0, W0, W0, W_PUSHM, W0, W_FETCH}, 6'd2};
        tbl[2]  = '{3'b000, 1'b0, 3'd6, {PSH, BW, POPB | AW, POPB, W0, W_FETCH}, 6'd1};
        tbl[3]  = '{3'b111, 1'b1, 3'd4, {W0, W0, PCS | PCW, TOSB, W0, W_FETCH}, 6'd1};
        tbl[4]  = '{3'b111, 1'b0, 3'd4, {W0, W0, PCS, TOSB, W0, W_FETCH}, 6'd1};
        tbl[5]  = '{3'b011, 1'b0, 3'd5, {W0, PSH, AW, POPB, W0, W_FETCH}, 6'd1};
        tbl[6]  = '{3'b100, 1'b0, 3'd3, {W0, W0, W0, W_PUSHM, W0, W_FETCH}, 6'd2};
        tbl[7]  = '{3'b001, 1'b0, 3'd6, {PSH, BW, POPB | AW, POPB, W0, W_FETCH}, 6'd1};
        tbl[8]  = '{3'b100, 1'b1, 3'd3, {W0, W0, W0, W_PUSHM, W0, W_FETCH}, 6'd2};
        tbl[9]  = '{3'b010, 1'b0, 3'd6, {PSH, BW, POPB | AW, POPB, W0, W_FETCH}, 6'd1};
        tbl[10] = '{3'b110, 1'b0, 3'd3, {W0, W0, W0, W_JUMP, W0, W_FETCH}, 6'd1};
        tbl[11] = '{3'b101, 1'b0, 3'd4, {W0, W0, W_STORE, POPB, W0, W_FETCH}, 6'd0};

        do_reset("init");
        go();
        for (int i = 0; i < 12; i++) apply($sformatf("v%0d", i), tbl[i]);
        err_seq("underflow", 3'b101, 6'd0);

        do_reset("ovf");
        go();
        for (int k = 0; k < 32; k++) begin
            pv = '{3'b100, 1'b0, 3'd3, {W0, W0, W0, W_PUSHM, W0, W_FETCH}, 6'(k + 1)};
            apply($sformatf("push%0d", k), pv);
        end
        err_seq("overflow", 3'b100, 6'd32);

        do_reset("mid");
        go();
        apply("mid_p0", tbl[0]);
        apply("mid_p1", tbl[1]);
        @(negedge clk);
        opcode_i = 3'b000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_pop2", {20'h0, ctrl_word()}, {20'h0, POPB | AW});
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_rst", {12'h0, ctrl_word(), busy_o, err_o, depth_o}, 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        start_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle%0d", c), {12'h0, ctrl_word(), busy_o, err_o, depth_o}, 32'h0);
        end
        go();
        apply("restart", tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/stack_cpu_ctrl.md
# stack_cpu_ctrl

Multi-cycle controller for the stack-based processor. It fetches and decodes each 8-bit instruction, then sequences the 32-entry operand stack (push/pop/tos pulses), the A/B operand latches, the ALU, data memory and the PC. It tracks stack occupancy itself and traps on overflow or underflow. It sits beside the stack, ALU and memory datapath and drives every control line of that datapath.

## Interface
- DEPTH, 32: stack capacity in entries; the occupancy counter is $clog2(DEPTH+1) bits wide.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; leaves IDLE when high
- opcode  in  3  IR[7:5]: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ
- zero  in  1  datapath flag, (stack output == 0)
- ir_write  out  1  load IR from memory data
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+1, 1 = IR[4:0]
- i_or_d  out  1  memory address: 0 = PC, 1 = IR[4:0]
- mem_read  out  1  memory read enable (async-read memory)
- mem_write  out  1  write stack output to mem[IR[4:0]]
- push, pop, tos  out  1 each  single-cycle stack commands; at most one is high in any cycle
- stk_src  out  1  stack input: 0 = ALU result, 1 = memory data
- a_write, b_write  out  1 each  latch stack output into A / B
- alu_op  out  2  equals opcode[1:0] combinationally, in every state
- depth  out  $clog2(DEPTH+1)  current stack occupancy
- busy  out  1  high in every state except IDLE and ERR
- err  out  1  sticky trap flag

## Operation
- States: IDLE, FETCH, DECODE, POP1, POP2, LATCH_B, LATCH_A, EXEC, PUSH_M, STORE, JUMP, TOS1, JZ_EVAL, ERR.
- All outputs are Moore, with two exceptions: alu_op, and pc_write in JZ_EVAL. Every output is 0 unless listed below.
- IDLE: stays in IDLE until start = 1, then goes to FETCH.
- FETCH: mem_read = 1, i_or_d = 0, ir_write = 1, pc_write = 1, pc_src = 0. Next state is DECODE.
- DECODE: no outputs. Performs the trap check, then branches on opcode.
  - ADD/SUB/AND: goes to POP1. Requires depth ≥ 2.
  - NOT: goes to POP1. Requires depth ≥ 1.
  - PUSH: goes to PUSH_M. Requires depth < DEPTH.
  - POP: goes to POP1. Requires depth ≥ 1.
  - JMP: goes to JUMP.
  - JZ: goes to TOS1. Requires depth ≥ 1.
  - If a requirement fails, the next state is ERR and no stack command is issued.
- POP1: pop = 1. Next state is POP2 for ADD/SUB/AND, LATCH_A for NOT, STORE for POP.
- POP2: pop = 1 and a_write = 1 (A = first-popped value, the old top). Next state is LATCH_B.
- LATCH_B: b_write = 1 (B = second-popped value). Next state is EXEC. The datapath computes B op A (SUB gives B − A).
- LATCH_A: a_write = 1. Next state is EXEC.
- EXEC: push = 1, stk_src = 0. Next state is FETCH.
- PUSH_M: mem_read = 1, i_or_d = 1, push = 1, stk_src = 1. Next state is FETCH.
- STORE: mem_write = 1, i_or_d = 1. Next state is FETCH.
- JUMP: pc_write = 1, pc_src = 1. Next state is FETCH.
- TOS1: tos = 1. Next state is JZ_EVAL.
- JZ_EVAL: pc_src = 1, pc_write = zero. Next state is FETCH. The stack is not popped.
- ERR: err = 1. All other outputs are 0. The only exit is rst_n.
- Depth counter:
  - +1 on each push cycle, −1 on each pop cycle; never wraps.
  - The trap check guarantees the counter stays within 0..DEPTH.
  - Net change per instruction: ADD/SUB/AND −1, NOT 0, PUSH +1, POP −1, JMP/JZ 0.

## Timing
- Reset: rst_n low forces, immediately and asynchronously, state = IDLE, depth = 0, err = 0 and all outputs to 0. This applies mid-instruction as well. The stack pointer must be reset in the same event; this block does not clear stack storage.
- The stack's output is registered: the value for a pop or tos issued in cycle n is valid in cycle n+1. This is why a_write follows the first pop by one cycle, and why zero is sampled in JZ_EVAL.
- Instruction lengths, counted from FETCH:
  - ADD/SUB/AND: 6 cycles
  - NOT: 5 cycles
  - PUSH: 3 cycles
  - POP: 4 cycles
  - JMP: 3 cycles
  - JZ: 4 cycles
- The PC increments in FETCH, so JZ not-taken falls through to PC+1.
- start is ignored outside IDLE.

## Test plan
- Reset, then start = 1, then opcode = 100 (PUSH). Cycle 1: ir_write = pc_write = 1, pc_src = 0. Cycle 3: push = mem_read = stk_src = i_or_d = 1. depth goes 0→1, and FETCH is re-entered on cycle 4.
- Two PUSHes, then ADD (000). pop pulses on cycles 3 and 4; a_write on cycle 4; b_write on cycle 5; cycle 6 has push = 1, stk_src = 0, alu_op = 00. depth goes 2→1.
- JZ (111) at depth 1. With zero = 1: tos on cycle 3, then pc_write = 1 with pc_src = 1 on cycle 4. With zero = 0: pc_write = 0 on cycle 4. depth stays 1 in both cases.
- POP (101) at depth 0. DECODE goes to ERR: err = 1, busy = 0, no pop pulse. The block remains in ERR for 20 cycles, until rst_n.
- PUSH at depth 32 (after 32 PUSHes) → ERR, with no push pulse. NOT at depth 1 → 5 cycles with pop, a_write and push in order; depth stays 1.
- rst_n low during POP2 of an ADD. All outputs are 0 in the same cycle, depth = 0 and the state is IDLE. After release, nothing happens until start.
